// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state type and radix-4 Booth digit encoding for the sequential multiplier
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit select packed as {neg, x2, x1}; zero has neither magnitude bit set
    localparam logic [2:0] DIG_ZERO = 3'b000;
    localparam logic [2:0] DIG_P1   = 3'b001;
    localparam logic [2:0] DIG_P2   = 3'b010;
    localparam logic [2:0] DIG_M1   = 3'b101;
    localparam logic [2:0] DIG_M2   = 3'b110;

endpackage

// File: rtl/booth_recoder.sv
// booth_recoder: maps an overlapping 3-bit multiplier window onto a radix-4 Booth digit select
module booth_recoder
    import mult_pkg::*;
(
    input  logic [2:0] bits_i,
    output logic       neg_o,
    output logic       x1_o,
    output logic       x2_o
);

    logic [2:0] sel;

    // Standard radix-4 table: window {b[i+1], b[i], b[i-1]} -> digit in {-2..+2}
    always_comb begin
        sel = DIG_ZERO;
        case (bits_i)
            3'b001, 3'b010: sel = DIG_P1;
            3'b011:         sel = DIG_P2;
            3'b100:         sel = DIG_M2;
            3'b101, 3'b110: sel = DIG_M1;
            default:        sel = DIG_ZERO;
        endcase
    end

    assign {neg_o, x2_o, x1_o} = sel;

endmodule

// File: rtl/booth_multiplier_seq.sv
// booth_multiplier_seq: iterative radix-4 Booth multiplier, one digit per cycle, valid/ready on both sides
module booth_multiplier_seq
    import mult_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           is_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product
);

    localparam int N  = W / 2 + 1;
    localparam int CW = $clog2(N);

    if (W < 4 || (W % 2) != 0) begin : g_bad_w
        $error("booth_multiplier_seq: W must be even and >= 4");
    end

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W+2:0]   mplier_q, mplier_d;
    logic [2*W-1:0] product_q;
    logic           in_ready_q;
    logic           out_valid_q;

    logic [2*W-1:0] a_ext;
    logic [W+2:0]   b_ext;
    logic [2*W-1:0] mag;
    logic           neg, x1, x2;

    // Operands are widened at capture so signed and unsigned share one datapath:
    // the multiplicand to the full result width, the multiplier to W+2 bits plus
    // the implicit zero below its LSB that seeds the first Booth window.
    assign a_ext = {{W{is_signed & a[W-1]}}, a};
    assign b_ext = {{2{is_signed & b[W-1]}}, b, 1'b0};

    booth_recoder u_recoder (
        .bits_i (mplier_q[2:0]),
        .neg_o  (neg),
        .x1_o   (x1),
        .x2_o   (x2)
    );

    // One Booth step: add the digit-weighted multiplicand, then advance both operands by two bit positions.
    // Working modulo 2^(2W) is exact because the true product always fits in 2W bits.
    always_comb begin
        mag      = x2 ? {mcand_q[2*W-2:0], 1'b0} : x1 ? mcand_q : '0;
        acc_d    = neg ? acc_q - mag : acc_q + mag;
        mcand_d  = {mcand_q[2*W-3:0], 2'b00};
        mplier_d = {{2{mplier_q[W+2]}}, mplier_q[W+2:2]};
    end

    // Control FSM with registered handshake outputs; reset overrides any state, including DONE under backpressure
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            product_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        mcand_q    <= a_ext;
                        mplier_q   <= b_ext;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_d;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) begin
                        product_q   <= acc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// tb_booth_multiplier_seq: table-driven, directed and scoreboard checks of the Booth multiplier at W=32 and W=8
module tb_booth_multiplier_seq;

    localparam int W  = 32;
    localparam int N  = W / 2 + 1;
    localparam int N8 = 5;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n, in_valid, in_ready, is_signed, out_valid, out_ready;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] product;
    logic           rst8_n, iv8, ir8, s8, ov8, or8;
    logic [7:0]     a8, b8;
    logic [15:0]    p8;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    bit          done8 = 1'b0;
    logic [63:0] sb_q[$];
    logic [63:0] sb8_q[$];
    int          lat_q[$];
    int          lat8_q[$];
    logic        ov_prev = 1'b0;
    logic        ov8_prev = 1'b0;

    booth_multiplier_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    booth_multiplier_seq #(.W(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst8_n),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .a         (a8),
        .b         (b8),
        .is_signed (s8),
        .out_valid (ov8),
        .out_ready (or8),
        .product   (p8)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic s, input int w);
        longint ex, ey;
        logic [63:0] p;
        if (w == 8) begin
            if (s) begin
                ex = longint'($signed(x[7:0]));
                ey = longint'($signed(y[7:0]));
            end else begin
                ex = longint'(x[7:0]);
                ey = longint'(y[7:0]);
            end
        end else begin
            if (s) begin
                ex = longint'($signed(x));
                ey = longint'($signed(y));
            end else begin
                ex = longint'(x);
                ey = longint'(y);
            end
        end
        p = 64'(ex * ey);
        return (w == 8) ? {48'd0, p[15:0]} : p;
    endfunction

    // Scoreboard for the W=32 instance: push on accept, pop on output handshake, latency per operation
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            lat_q.delete();
        end else begin
            if (out_valid && !ov_prev) begin
                check("valid_has_op", 64'(lat_q.size() != 0), 64'd1);
                if (lat_q.size() != 0) check("latency", 64'(cyc - lat_q.pop_front() - 1), 64'(N));
            end
            if (out_valid && out_ready) begin
                check("sb_has_exp", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) check("sb_product", product, sb_q.pop_front());
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(ref_mul(a, b, is_signed, 32));
                lat_q.push_back(cyc);
            end
        end
        ov_prev = out_valid && rst_n;
    end

    // Scoreboard for the W=8 instance
    always @(negedge clk) begin
        if (!rst8_n) begin
            sb8_q.delete();
            lat8_q.delete();
        end else begin
            if (ov8 && !ov8_prev) begin
                check("w8_valid_has_op", 64'(lat8_q.size() != 0), 64'd1);
                if (lat8_q.size() != 0) check("w8_latency", 64'(cyc - lat8_q.pop_front() - 1), 64'(N8));
            end
            if (ov8 && or8) begin
                check("w8_sb_has_exp", 64'(sb8_q.size() != 0), 64'd1);
                if (sb8_q.size() != 0) check("w8_sb_product", {48'd0, p8}, sb8_q.pop_front());
            end
            if (iv8 && ir8) begin
                sb8_q.push_back(ref_mul({24'd0, a8}, {24'd0, b8}, s8, 8));
                lat8_q.push_back(cyc);
            end
        end
        ov8_prev = ov8 && rst8_n;
    end

    // Called just after a rising edge; returns just after the accept edge
    task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic ts);
        int k = 0;
        a = ta;
        b = tb;
        is_signed = ts;
        in_valid = 1'b1;
        while (!in_ready && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("send_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Waits for out_valid with out_ready high; returns just after the handshake edge
    task automatic recv(output logic [63:0] p);
        int k = 0;
        out_ready = 1'b1;
        while (!out_valid && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("recv_valid", 64'(out_valid), 64'd1);
        p = product;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t        vecs[11];
        logic [63:0] p;
        int          k;
        bit          seen;
        logic        hs;
        vecs[0]  = '{"s_15x10",        32'd15,         32'd10,         1'b1, 64'd150};
        vecs[1]  = '{"s_m25x12",       32'hFFFF_FFE7,  32'd12,         1'b1, 64'hFFFF_FFFF_FFFF_FED4};
        vecs[2]  = '{"s_m8xm8",        32'hFFFF_FFF8,  32'hFFFF_FFF8,  1'b1, 64'd64};
        vecs[3]  = '{"s_0x123",        32'd0,          32'd123,        1'b1, 64'd0};
        vecs[4]  = '{"s_max_sq",       32'h7FFF_FFFF,  32'h7FFF_FFFF,  1'b1, 64'h3FFF_FFFF_0000_0001};
        vecs[5]  = '{"s_min_sq",       32'h8000_0000,  32'h8000_0000,  1'b1, 64'h4000_0000_0000_0000};
        vecs[6]  = '{"u_max_sq",       32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 64'hFFFF_FFFE_0000_0001};
        vecs[7]  = '{"u_min_x2",       32'h8000_0000,  32'd2,          1'b0, 64'h0000_0001_0000_0000};
        vecs[8]  = '{"s_m1x1",         32'hFFFF_FFFF,  32'd1,          1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[9]  = '{"u_max_x1",       32'hFFFF_FFFF,  32'd1,          1'b0, 64'h0000_0000_FFFF_FFFF};
        vecs[10] = '{"s_min_x_max",    32'h8000_0000,  32'h7FFF_FFFF,  1'b1, 64'hC000_0000_8000_0000};

        // Reset with in_valid held high: must be ignored
        rst_n = 1'b0;
        in_valid = 1'b1;
        a = 32'd5;
        b = 32'd5;
        is_signed = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_product", product, 64'd0);

        for (int i = 0; i < 11; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].s);
            recv(p);
            check(vecs[i].name, p, vecs[i].exp);
        end

        // Backpressure: DONE held for 10 cycles while new operands are offered
        send(32'd1000, 32'hFFFF_FFFD, 1'b1);
        k = 0;
        while (!out_valid && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        for (int i = 0; i < 10; i++) begin
            a = 32'($urandom);
            b = 32'($urandom);
            in_valid = 1'b1;
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_product", product, 64'hFFFF_FFFF_FFFF_F448);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        recv(p);
        check("bp_result", p, 64'hFFFF_FFFF_FFFF_F448);
        check("post_hs_in_ready", 64'(in_ready), 64'd1);
        check("post_hs_out_valid", 64'(out_valid), 64'd0);

        // Reset at CALC iteration 5 discards the operation
        send(32'd100, 32'd200, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_product", product, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            seen |= out_valid;
            @(posedge clk); #1;
        end
        check("midrst_no_valid", 64'(seen), 64'd0);
        send(32'd3, 32'd7, 1'b0);
        recv(p);
        check("midrst_3x7", p, 64'd21);

        // Operands change every cycle while the multiply is in flight
        send(32'd6, 32'd7, 1'b1);
        k = 0;
        while (!out_valid && k < 200) begin
            a = 32'($urandom);
            b = 32'($urandom);
            is_signed = 1'($urandom);
            @(posedge clk); #1;
            k++;
        end
        recv(p);
        check("inflight_6x7", p, 64'd42);

        // Random regression with random output stalls
        for (int i = 0; i < 1000; i++) begin
            send(($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom),
                 ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom),
                 1'($urandom));
            k = 0;
            do begin
                out_ready = 1'($urandom);
                hs = out_valid && out_ready;
                @(posedge clk); #1;
                k++;
            end while (!hs && k < 300);
            check("rand_handshake", 64'(hs), 64'd1);
            out_ready = 1'b0;
        end

        k = 0;
        while (!done8 && k < 60000) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("w8_done", 64'(done8), 64'd1);
        check("sb_drain", 64'(sb_q.size()), 64'd0);
        check("sb8_drain", 64'(sb8_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // W=8 random regression, concurrent with the W=32 sequence
    initial begin
        int   k;
        logic hs;
        rst8_n = 1'b0;
        iv8 = 1'b0;
        a8 = 8'd0;
        b8 = 8'd0;
        s8 = 1'b0;
        or8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst8_n = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            a8 = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
            b8 = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            s8 = 1'($urandom);
            iv8 = 1'b1;
            k = 0;
            while (!ir8 && k < 50) begin
                @(posedge clk); #1;
                k++;
            end
            check("w8_send_ready", 64'(ir8), 64'd1);
            @(posedge clk); #1;
            iv8 = 1'b0;
            k = 0;
            do begin
                or8 = 1'($urandom);
                hs = ov8 && or8;
                @(posedge clk); #1;
                k++;
            end while (!hs && k < 100);
            check("w8_handshake", 64'(hs), 64'd1);
            or8 = 1'b0;
        end
        done8 = 1'b1;
    end

endmodule
